// File: rtl/div_unit_pkg.sv
// Shared decode constants, divider state encoding and widths.
package div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RES_W = 2 * XLEN;
  localparam int unsigned CNT_W = 5;

  // R-type opcode and funct codes of the HI/LO-writing divides
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

  localparam logic [RES_W-1:0] DIV_ZERO_RESULT = 64'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// E-stage <-> divider handshake and operand/result bus.
interface div_unit_if import div_unit_pkg::*;;

  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [RES_W-1:0] result;
  logic             ready;
  logic             busy;

  modport master (
    output start, signed_div, cancel, a, b,
    input  result, ready, busy
  );

  modport slave (
    input  start, signed_div, cancel, a, b,
    output result, ready, busy
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider producing {HI=remainder, LO=quotient}.
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_t       state;
  div_state_t       state_next;
  logic             accept;
  logic             last_iter;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] acc;        // {partial remainder, dividend/quotient}
  logic [XLEN-1:0]  dvsr;
  logic             neg_q;
  logic             neg_r;
  logic [RES_W-1:0] result_q;
  logic             ready_q;
  logic             busy_q;

  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;
  logic [XLEN:0]    trial;
  logic [RES_W-1:0] acc_step;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; cancel overrides everything, including a start in IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = (cnt == CNT_W'(XLEN - 1));
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          accept     = 1'b1;
          state_next = (bus.b == '0) ? FINISH : DIV;
        end
      end
      DIV:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.cancel) state_next = IDLE;
  end

  // Operand magnitudes, one restoring step, and output sign fix
  always_comb begin
    mag_a    = (bus.signed_div && bus.a[XLEN-1]) ? -bus.a : bus.a;
    mag_b    = (bus.signed_div && bus.b[XLEN-1]) ? -bus.b : bus.b;
    trial    = acc[RES_W-1:XLEN-1] - {1'b0, dvsr};
    acc_step = trial[XLEN] ? {acc[RES_W-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    q_fix    = neg_q ? -acc_step[XLEN-1:0]     : acc_step[XLEN-1:0];
    r_fix    = neg_r ? -acc_step[RES_W-1:XLEN] : acc_step[RES_W-1:XLEN];
  end

  // Datapath, result and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= (state_next == FINISH);
      busy_q  <= (state_next == DIV);
      if (accept) begin
        cnt <= '0;
        if (bus.b == '0) begin
          result_q <= DIV_ZERO_RESULT;
        end else begin
          acc   <= {{XLEN{1'b0}}, mag_a};
          dvsr  <= mag_b;
          neg_q <= bus.signed_div & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
          neg_r <= bus.signed_div & bus.a[XLEN-1];
        end
      end else if (state == DIV && !bus.cancel) begin
        acc <= acc_step;
        cnt <= CNT_W'(cnt + CNT_W'(1));
        if (last_iter) result_q <= {r_fix, q_fix};
      end
    end
  end

  // A cancel in the completion cycle suppresses the pulse immediately
  assign bus.ready  = ready_q & ~bus.cancel;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the execute stage. It consumes the DIV/DIVU instructions flagged by the main decoder as HI/LO writers and produces the {HI, LO} pair that the M-stage HI/LO register commits. The hazard unit holds the E stage while a division is in flight. An exception flush cancels a division without any write.

## Interface
Parameters:
- none. The width is fixed at 32/64.

Ports:
- clk  in  1  core clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  a DIV/DIVU is in E with its operands valid. Held high by the E-stage stall until `ready`.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- cancel  in  1  flush from an exception or flushE. Aborts any operation.
- a  in  32  dividend (rs). Sampled when `start` is accepted.
- b  in  32  divisor (rt). Sampled when `start` is accepted.
- result  out  64  {remainder → HI[63:32], quotient → LO[31:0]}. Registered.
- ready  out  1  one-cycle pulse: `result` is valid this cycle.
- busy  out  1  high while in DIV. Used by the hazard unit as part of stallE = start & ~ready.

## Operation
- States: IDLE, DIV, FINISH. Reset puts the block in IDLE with result=0, ready=0, busy=0, and the iteration counter at 0.
- IDLE:
  - start=1 & cancel=0 & b≠0: latch |a|, |b| (magnitudes if signed_div, raw otherwise), latch the quotient and remainder sign flags, then go to DIV with cnt=0.
  - start=1 & cancel=0 & b=0: result ← 64'h0, go to FINISH.
- DIV: restoring radix-2, one quotient bit per cycle, MSB first.
  - Use a 33-bit partial-remainder subtract.
  - cnt increments each cycle. The 32nd iteration (cnt=31) writes the sign-fixed result and goes to FINISH.
- FINISH: ready=1 for this cycle only, then go to IDLE unconditionally. A `start` seen in FINISH is ignored; the next division is accepted in IDLE.
- Sign fix (signed only):
  - Quotient is negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with wrap and no trap.
- cancel:
  - In any state, the next state is IDLE.
  - ready is forced low in that cycle and is never raised for the cancelled operation.
  - result keeps its previous value.
  - cancel and start in the same cycle: cancel wins and the start is not accepted.
- start while in DIV is ignored. Operands are only ever taken from the accepted cycle, so a/b changing mid-operation has no effect.
- Reset asserted mid-operation returns the block to its reset values immediately, without waiting for the clock.

## Timing
- start accepted in cycle T with b≠0: busy=1 in cycles T+1 … T+32, ready=1 and result valid in T+33. Latency is 33 cycles.
- Divide-by-zero accepted in T: busy stays 0, ready=1 in T+1.
- result is stable from the ready cycle until the next completed operation.
- Minimum spacing between accepted starts is the ready cycle plus one IDLE cycle.
- ready and busy are never high in the same cycle.

## Structure
- Put the state encoding (2-bit: IDLE, DIV, FINISH) and DIV_ZERO_RESULT (64'h0) in the shared defines header, next to the opcode and funct constants.
- One module, no sub-module. The iterative datapath is 33-bit subtract, 64-bit shift register and 5-bit counter. Sign handling is combinational input/output negation in the same module.

## Test plan
- DIVU a=100, b=7 → ready in T+33, result = {32'd2, 32'd14}. busy high for exactly 32 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV a=7, b=0xFFFFFFFE → LO=0xFFFFFFFD, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU of the same operands → LO=0, HI=0x80000000.
- Divide-by-zero: DIVU 5/0 → ready in T+1, result=0, busy never high.
- Cancel at T+10 of DIVU 100/7, with the previous result 0x1234: busy low from T+11, no ready pulse, result still 0x1234. A new DIVU 0xFFFFFFFF/1 started next → {0, 0xFFFFFFFF} after 33 cycles.
- Start with a/b toggled while busy, and start+cancel in the same IDLE cycle → the original result is unaffected and the start+cancel start is not accepted. Async rst pulse mid-DIV → all outputs 0 immediately.
